trng_entropy_sequencer: RTL and testbench
=========================================

Name: trng_entropy_sequencer

Overview:
Harvests bytes from the external 8-bit random source. Runs a continuous repetition-count health test on every byte. Packs passing bytes into 32-bit words and buffers them in a small FIFO for the processor-side seed register path. Sits between the random-source input pins and the 32-bit random-seed consumer, and sequences sampling rate, health checking and flow control.

Parameters:
SAMPLE_DIV, 16, clock cycles between samples; legal range 2..65535.
REP_LIMIT, 8, number of identical consecutive samples that trips the health test; legal range 2..255.
FIFO_DEPTH, 4, words held in the output FIFO; must be a power of 2, range 2..16.

Ports:
clk_clk  in  1  system clock.
reset_reset_n  in  1  asynchronous active-low reset.
enable  in  1  level; 1 = harvest.
pi_random  in  8  raw random byte; asynchronous to clk_clk.
seed_ready  in  1  consumer accepts the current word.
clear_fail  in  1  one-cycle pulse; clears a health failure.
seed_valid  out  1  FIFO head word valid.
seed_data  out  32  FIFO head word.
health_fail  out  1  sticky health-test failure flag.
fifo_level  out  log2(FIFO_DEPTH)+1  words currently stored.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, all counters 0, sync flops 0. Reset mid-operation discards everything immediately.
- Input synchronisation: pi_random passes through a 2-flop synchroniser (samp_sync). The sampled value is samp_sync.
- States and transitions:
  - IDLE: go to SAMPLE when enable=1 and health_fail=0.
  - SAMPLE: runs div_cnt from 0 to SAMPLE_DIV-1 and wraps to 0.
    - div_cnt increments only when the FIFO is not full or a pop happens in the same cycle. Otherwise div_cnt holds (stall; no samples are lost or taken).
    - A sample event occurs on the cycle where div_cnt==SAMPLE_DIV-1 and div_cnt is not stalled.
    - enable=0 returns to IDLE next cycle. div_cnt, byte_idx, partial word and rep_cnt clear. The FIFO is retained.
  - FAIL: entered from a health trip.
    - health_fail=1.
    - No sampling.
    - FIFO and partial word are flushed on entry, so fifo_level=0 and seed_valid=0 the next cycle.
    - clear_fail=1 goes to IDLE and clears health_fail. clear_fail in any other state is ignored.
- Repetition test, evaluated on each sample event:
  - The first sample after entering SAMPLE sets rep_cnt=1 and prev=sample.
  - A sample equal to prev increments rep_cnt. A different sample sets rep_cnt=1.
  - If the incremented rep_cnt would equal REP_LIMIT, the byte is discarded and the next state is FAIL.
- Packing:
  - Passing bytes fill the word little-endian: byte_idx 0 goes to [7:0], 1 to [15:8], 2 to [23:16], 3 to [31:24].
  - On the byte_idx 3 sample event, the full word is written into the FIFO on that same edge and byte_idx wraps to 0.
  - The stall rule guarantees the FIFO is never written while full.
- FIFO:
  - First-word-fall-through. seed_valid = (fifo_level != 0). seed_data = head word.
  - A pop occurs when seed_valid and seed_ready are both 1. seed_data holds stable while seed_valid=1 and seed_ready=0.
  - Simultaneous push and pop leaves fifo_level unchanged and is legal when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is registered and updates on the same edge as the push or pop.
- Latency: from entering SAMPLE with no stall, the first push happens on cycle 4*SAMPLE_DIV. seed_valid rises 1 cycle after the push.
- Simultaneous events:
  - A health trip on the same cycle as a pop gives FAIL with the flush taking priority.
  - enable=0 on the same cycle as a sample event drops that sample.

Test Plan:
- SAMPLE_DIV=4, pi_random stepping 0x11,0x22,0x33,0x44 once per sample, seed_ready=1 -> seed_valid pulses with seed_data=0x44332211; first word present at cycle 16 after SAMPLE entry; health_fail stays 0.
- seed_ready=0, incrementing bytes, FIFO_DEPTH=4 -> fifo_level reaches 4, then div_cnt stalls and no further samples are taken. Raise seed_ready for 1 cycle -> fifo_level=3 and sampling resumes. Words pop in order with no loss.
- REP_LIMIT=8, pi_random held at 0xA5 -> health_fail=1 on the 8th sample event; FIFO flushed (fifo_level=0). clear_fail pulse -> health_fail=0 and sampling restarts.
- pi_random alternating 7 equal samples then a different one, repeatedly -> health_fail never asserts; words packed correctly.
- Drop enable after 2 bytes of a word, then re-enable -> the partial word is discarded; the next word is built from 4 fresh bytes; previously stored FIFO words are unchanged.
- Assert reset_reset_n=0 mid-word with 2 words stored -> all outputs 0 immediately, fifo_level=0, state IDLE.

Source files
------------

// File: rtl/trng_entropy_sequencer.sv
// trng_entropy_sequencer: samples an asynchronous 8-bit random source at a
// programmable rate, runs a repetition-count health test on every sample and
// packs passing bytes little-endian into 32-bit words queued in a small
// first-word-fall-through FIFO for the seed consumer.
module trng_entropy_sequencer #(
  parameter int SAMPLE_DIV = 16,
  parameter int REP_LIMIT  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic [7:0]                    pi_random,
  input  logic                          seed_ready,
  input  logic                          clear_fail,
  output logic                          seed_valid,
  output logic [31:0]                   seed_data,
  output logic                          health_fail,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [15:0]      DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [7:0]       REP_TRIP = 8'(REP_LIMIT);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    FAIL   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]       samp_meta;
  logic [7:0]       samp_sync;
  logic [15:0]      div_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      partial;
  logic [7:0]       rep_cnt;
  logic [7:0]       prev;
  logic [7:0]       rep_next;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic        fifo_full;
  logic        pop;
  logic        stall;
  logic        div_adv;
  logic        sample_evt;
  logic        trip;
  logic        push;
  logic        hold_clear;
  logic [31:0] push_word;

  // Datapath decode: stall when full without a pop, sample on the last divider count
  assign fifo_full   = (level == FULL_LVL);
  assign seed_valid  = (level != '0);
  assign seed_data   = seed_valid ? mem[rd_ptr] : 32'h0;
  assign fifo_level  = level;
  assign health_fail = (state == FAIL);
  assign pop         = seed_valid && seed_ready;
  assign stall       = fifo_full && !pop;
  assign div_adv     = (state == SAMPLE) && enable && !stall;
  assign sample_evt  = div_adv && (div_cnt == DIV_LAST);
  assign rep_next    = (rep_cnt == 8'd0)   ? 8'd1 :
                       (samp_sync == prev) ? rep_cnt + 8'd1 : 8'd1;
  assign trip        = sample_evt && (rep_next == REP_TRIP);
  assign push        = sample_evt && !trip && (byte_idx == 2'd3);
  assign push_word   = {samp_sync, partial};
  assign hold_clear  = (state != SAMPLE) || !enable || trip;

  // Two-flop synchroniser for the asynchronous random source
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      samp_meta <= 8'h0;
      samp_sync <= 8'h0;
    end else begin
      samp_meta <= pi_random;
      samp_sync <= samp_meta;
    end
  end

  // State register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a health trip wins over everything except leaving on enable=0
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (!enable)   state_next = IDLE;
        else if (trip) state_next = FAIL;
      end
      FAIL: begin
        if (clear_fail) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample divider, repetition counter and partial-word packing
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt  <= 16'h0;
      byte_idx <= 2'd0;
      partial  <= 24'h0;
      rep_cnt  <= 8'h0;
      prev     <= 8'h0;
    end else if (hold_clear) begin
      div_cnt  <= 16'h0;
      byte_idx <= 2'd0;
      partial  <= 24'h0;
      rep_cnt  <= 8'h0;
      prev     <= 8'h0;
    end else begin
      if (div_adv) begin
        div_cnt <= (div_cnt == DIV_LAST) ? 16'h0 : div_cnt + 16'd1;
      end
      if (sample_evt) begin
        rep_cnt  <= rep_next;
        prev     <= samp_sync;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    partial[7:0]   <= samp_sync;
          2'd1:    partial[15:8]  <= samp_sync;
          2'd2:    partial[23:16] <= samp_sync;
          default: partial        <= 24'h0;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; a health trip flushes the queue
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (trip) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // FIFO storage; contents are masked by seed_valid so no reset is needed
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_trng_entropy_sequencer.sv
// tb_trng_entropy_sequencer: directed scenarios for the entropy sequencer with
// SAMPLE_DIV=4, REP_LIMIT=8, FIFO_DEPTH=4 and hand-computed expected words.
module tb_trng_entropy_sequencer;

  localparam int SDIV  = 4;
  localparam int RLIM  = 8;
  localparam int DEPTH = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic [7:0]  pi_random;
  logic        seed_ready;
  logic        clear_fail;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        health_fail;
  logic [2:0]  fifo_level;

  int compared   = 0;
  int mismatched = 0;

  trng_entropy_sequencer #(
    .SAMPLE_DIV(SDIV),
    .REP_LIMIT (RLIM),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .enable       (enable),
    .pi_random    (pi_random),
    .seed_ready   (seed_ready),
    .clear_fail   (clear_fail),
    .seed_valid   (seed_valid),
    .seed_data    (seed_data),
    .health_fail  (health_fail),
    .fifo_level   (fifo_level)
  );

  // Free-running 10-unit clock
  always #5 clk_clk = ~clk_clk;

  task automatic do_reset();
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    pi_random     = 8'h00;
    seed_ready    = 1'b0;
    clear_fail    = 1'b0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  // Wait through the next sample edge, then present the following byte
  task automatic next_sample(input logic [7:0] nb);
    repeat (SDIV) @(posedge clk_clk);
    #1;
    pi_random = nb;
  endtask

  task automatic pop_one();
    seed_ready = 1'b1;
    @(posedge clk_clk);
    #1;
    seed_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    enable = 1'b0; pi_random = 8'h00; seed_ready = 1'b0; clear_fail = 1'b0;
    #1;
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %0b want 0", seed_valid); end
    compared++; if (seed_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %08h want 00000000", seed_data); end
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hf: got %0b want 0", health_fail); end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (10) @(posedge clk_clk);
    #1;
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idle_valid: got %0b want 0", seed_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    pi_random = 8'h11; enable = 1'b1; seed_ready = 1'b1;
    @(posedge clk_clk); #1;
    next_sample(8'h22);
    next_sample(8'h33);
    next_sample(8'h44);
    repeat (3) @(posedge clk_clk); #1;
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_early_valid: got %0b want 0", seed_valid); end
    @(posedge clk_clk); #1;
    compared++; if (seed_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_valid: got %0b want 1", seed_valid); end
    compared++; if (seed_data !== 32'h44332211) begin mismatched++; $display("[TB] FAIL basic_data: got %08h want 44332211", seed_data); end
    compared++; if (fifo_level !== 3'd1) begin mismatched++; $display("[TB] FAIL basic_level: got %0d want 1", fifo_level); end
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_hf: got %0b want 0", health_fail); end
    @(posedge clk_clk); #1;
    enable = 1'b0;
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_popped: got %0b want 0", seed_valid); end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL basic_level0: got %0d want 0", fifo_level); end
    seed_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] exp_words [4];
    exp_words[0] = 32'h17161514;
    exp_words[1] = 32'h1B1A1918;
    exp_words[2] = 32'h1F1E1D1C;
    exp_words[3] = 32'h23222120;
    do_reset();
    pi_random = 8'h10; enable = 1'b1; seed_ready = 1'b0;
    @(posedge clk_clk); #1;
    for (int i = 1; i < 16; i++) next_sample(8'(8'h10 + i));
    next_sample(8'hEE);
    compared++; if (fifo_level !== 3'd4) begin mismatched++; $display("[TB] FAIL stall_full: got %0d want 4", fifo_level); end
    repeat (20) @(posedge clk_clk); #1;
    compared++; if (fifo_level !== 3'd4) begin mismatched++; $display("[TB] FAIL stall_hold: got %0d want 4", fifo_level); end
    compared++; if (seed_data !== 32'h13121110) begin mismatched++; $display("[TB] FAIL stall_head0: got %08h want 13121110", seed_data); end
    pi_random = 8'h20;
    repeat (4) @(posedge clk_clk); #1;
    pop_one();
    compared++; if (fifo_level !== 3'd3) begin mismatched++; $display("[TB] FAIL stall_pop_level: got %0d want 3", fifo_level); end
    repeat (2) @(posedge clk_clk);
    @(posedge clk_clk); #1;
    pi_random = 8'h21;
    next_sample(8'h22);
    next_sample(8'h23);
    repeat (4) @(posedge clk_clk); #1;
    compared++; if (fifo_level !== 3'd4) begin mismatched++; $display("[TB] FAIL stall_resume_level: got %0d want 4", fifo_level); end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++; if (seed_data !== exp_words[i]) begin mismatched++; $display("[TB] FAIL stall_word%0d: got %08h want %08h", i + 1, seed_data, exp_words[i]); end
      pop_one();
    end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL stall_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_rep_pattern();
    logic [7:0]  pat [16];
    logic [31:0] exp_words [4];
    for (int i = 0; i < 16; i++) pat[i] = ((i % 8) == 7) ? 8'h3C : 8'h5A;
    exp_words[0] = 32'h5A5A5A5A;
    exp_words[1] = 32'h3C5A5A5A;
    exp_words[2] = 32'h5A5A5A5A;
    exp_words[3] = 32'h3C5A5A5A;
    do_reset();
    pi_random = pat[0]; enable = 1'b1; seed_ready = 1'b0;
    @(posedge clk_clk); #1;
    for (int i = 1; i < 16; i++) next_sample(pat[i]);
    repeat (4) @(posedge clk_clk); #1;
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL rep7_hf: got %0b want 0", health_fail); end
    compared++; if (fifo_level !== 3'd4) begin mismatched++; $display("[TB] FAIL rep7_level: got %0d want 4", fifo_level); end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++; if (seed_data !== exp_words[i]) begin mismatched++; $display("[TB] FAIL rep7_word%0d: got %08h want %08h", i, seed_data, exp_words[i]); end
      pop_one();
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    pi_random = 8'h21; enable = 1'b1; seed_ready = 1'b0;
    @(posedge clk_clk); #1;
    next_sample(8'h22);
    next_sample(8'h23);
    next_sample(8'h24);
    next_sample(8'h31);
    next_sample(8'h32);
    repeat (4) @(posedge clk_clk); #1;
    enable = 1'b0;
    compared++; if (fifo_level !== 3'd1) begin mismatched++; $display("[TB] FAIL endrop_level1: got %0d want 1", fifo_level); end
    @(posedge clk_clk);
    @(negedge clk_clk);
    pi_random = 8'h41; enable = 1'b1;
    @(posedge clk_clk); #1;
    next_sample(8'h42);
    next_sample(8'h43);
    next_sample(8'h44);
    repeat (4) @(posedge clk_clk); #1;
    enable = 1'b0;
    compared++; if (fifo_level !== 3'd2) begin mismatched++; $display("[TB] FAIL endrop_level2: got %0d want 2", fifo_level); end
    compared++; if (seed_data !== 32'h24232221) begin mismatched++; $display("[TB] FAIL endrop_old_word: got %08h want 24232221", seed_data); end
    pop_one();
    compared++; if (seed_data !== 32'h44434241) begin mismatched++; $display("[TB] FAIL endrop_new_word: got %08h want 44434241", seed_data); end
    pop_one();
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL endrop_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_health();
    do_reset();
    pi_random = 8'hA5; enable = 1'b1; seed_ready = 1'b0;
    @(posedge clk_clk); #1;
    repeat (31) @(posedge clk_clk); #1;
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL health_pre_hf: got %0b want 0", health_fail); end
    compared++; if (fifo_level !== 3'd1) begin mismatched++; $display("[TB] FAIL health_pre_level: got %0d want 1", fifo_level); end
    @(posedge clk_clk); #1;
    compared++; if (health_fail !== 1'b1) begin mismatched++; $display("[TB] FAIL health_trip: got %0b want 1", health_fail); end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL health_flush_level: got %0d want 0", fifo_level); end
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL health_flush_valid: got %0b want 0", seed_valid); end
    pi_random = 8'h01;
    repeat (10) @(posedge clk_clk); #1;
    compared++; if (health_fail !== 1'b1) begin mismatched++; $display("[TB] FAIL health_sticky: got %0b want 1", health_fail); end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL health_nosample: got %0d want 0", fifo_level); end
    clear_fail = 1'b1;
    @(posedge clk_clk); #1;
    clear_fail = 1'b0;
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL health_clear: got %0b want 0", health_fail); end
    @(posedge clk_clk); #1;
    next_sample(8'h02);
    next_sample(8'h03);
    next_sample(8'h04);
    repeat (4) @(posedge clk_clk); #1;
    enable = 1'b0;
    compared++; if (seed_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL health_restart_valid: got %0b want 1", seed_valid); end
    compared++; if (seed_data !== 32'h04030201) begin mismatched++; $display("[TB] FAIL health_restart_data: got %08h want 04030201", seed_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pi_random = 8'h51; enable = 1'b1; seed_ready = 1'b0;
    @(posedge clk_clk); #1;
    for (int i = 2; i <= 10; i++) next_sample(8'(8'h50 + i));
    repeat (4) @(posedge clk_clk); #1;
    compared++; if (fifo_level !== 3'd2) begin mismatched++; $display("[TB] FAIL rstmid_pre_level: got %0d want 2", fifo_level); end
    #2;
    reset_reset_n = 1'b0;
    #1;
    compared++; if (seed_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_valid: got %0b want 0", seed_valid); end
    compared++; if (seed_data !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_data: got %08h want 00000000", seed_data); end
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_level: got %0d want 0", fifo_level); end
    compared++; if (health_fail !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_hf: got %0b want 0", health_fail); end
    enable = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (20) @(posedge clk_clk); #1;
    compared++; if (fifo_level !== 3'd0) begin mismatched++; $display("[TB] FAIL rstmid_idle_level: got %0d want 0", fifo_level); end
  endtask

  // Run every scenario in order and report
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_rep_pattern();
    test_enable_drop();
    test_health();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
